// File: rtl/dmem_responder.sv
// Single-port data memory that answers RV32I loads/stores over a valid/ready
// request/response handshake, with a configurable number of wait states.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // state  | meaning
    // S_IDLE | ready for a request (only state with req_ready=1)
    // S_WAIT | counting WAIT_STATES cycles after accept
    // S_RESP | response held until rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0] mem [0:DEPTH-1];

    state_t      state;
    logic [2:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_wdata;

    logic             accept;
    logic             enter_resp;
    logic             a_we;
    logic [31:0]      a_addr;
    logic [2:0]       a_funct3;
    logic [31:0]      a_wdata;
    logic [IDX_W-1:0] a_idx;
    logic [1:0]       a_lane;
    logic             a_err;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [31:0]      rsp_data;
    logic [3:0]       wmask;
    logic [31:0]      wdata_rep;
    logic             mem_write;

    assign accept = req_valid & req_ready;

    // With zero wait states the access happens on the accept edge itself,
    // so the live request is used instead of the latched copy.
    assign a_we     = (state == S_IDLE) ? req_we     : lat_we;
    assign a_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
    assign a_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
    assign a_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
    assign a_idx    = a_addr[IDX_W+1:2];
    assign a_lane   = a_addr[1:0];

    assign enter_resp = (WAIT_STATES == 0) ? accept
                                           : ((state == S_WAIT) && (cnt == WS_LAST));

    always_comb begin
        a_err = 1'b0;
        if ({2'b00, a_addr[31:2]} >= 32'(DEPTH)) a_err = 1'b1;
        case (a_funct3)
            F3_B, F3_BU: ;
            F3_H, F3_HU: if (a_addr[0]) a_err = 1'b1;
            F3_W:        if (a_addr[1:0] != 2'b00) a_err = 1'b1;
            default:     a_err = 1'b1;
        endcase
        if (a_we && a_funct3[2]) a_err = 1'b1;
    end

    assign rd_word  = mem[a_idx];
    assign rd_shift = rd_word >> {a_lane, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = a_lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'h0;
        case (a_funct3)
            F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
            F3_W:    load_data = rd_word;
            F3_BU:   load_data = {24'h0, rd_byte};
            F3_HU:   load_data = {16'h0, rd_half};
            default: load_data = 32'h0;
        endcase
    end

    assign rsp_data = (a_err || a_we) ? 32'h0 : load_data;

    always_comb begin
        wmask     = 4'b1111;
        wdata_rep = a_wdata;
        case (a_funct3[1:0])
            2'b00: begin
                wmask     = 4'b0001 << a_lane;
                wdata_rep = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                wmask     = a_lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{a_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Gating with reset keeps an access from landing on an edge that reset overlaps.
    assign mem_write = enter_resp & a_we & ~a_err & reset;

    always_ff @(posedge clk) begin
        if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[a_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
            cnt        <= 3'd0;
            lat_we     <= 1'b0;
            lat_addr   <= 32'h0;
            lat_funct3 <= 3'd0;
            lat_wdata  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_we     <= req_we;
                        lat_addr   <= req_addr;
                        lat_funct3 <= req_funct3;
                        lat_wdata  <= req_wdata;
                        cnt        <= 3'd0;
                        req_ready  <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != WS_LAST) cnt <= cnt + 3'd1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (enter_resp) begin
                state     <= S_RESP;
                rsp_valid <= 1'b1;
                rsp_rdata <= rsp_data;
                rsp_err   <= a_err;
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit data words; legal range 4..1024, power of two.
REQ-002 Parameter WAIT_STATES, default 1, extra cycles between request accept and response; legal range 0..7.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 req_valid  input  1  CPU load/store request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_wdata  input  32  store data; low-order bytes used for SB/SH.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  CPU accepts response.
REQ-013 rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 rsp_err  output  1  request rejected: misaligned, out of range, or illegal funct3.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept = req_valid & req_ready; on accept, latch we, addr, funct3, wdata; next state is WAIT if WAIT_STATES>0, else RESP.
REQ-017 WAIT SHALL count WAIT_STATES cycles using a 3-bit counter cleared on accept, then go to RESP.
REQ-018 Memory access (store write or load read) SHALL occur on the clock edge entering RESP; rsp_valid, rsp_rdata, and rsp_err SHALL be registered and valid throughout RESP.
REQ-019 Accept-to-rsp_valid latency SHALL be WAIT_STATES+1 cycles.
REQ-020 In RESP, rsp_valid=1; the response SHALL hold stable until rsp_ready=1, then return to IDLE on that edge.
REQ-021 No new request SHALL be accepted in the RESP→IDLE cycle; minimum request spacing is WAIT_STATES+2 cycles.
REQ-022 Word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
REQ-023 Error if any of the following holds: addr[31:2] >= DEPTH; H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3[2]=1.
REQ-024 On error: no memory write, rsp_rdata=0, rsp_err=1, full handshake still completed.
REQ-025 SB SHALL write only byte lane addr[1:0] from wdata[7:0].
REQ-026 SH SHALL write only lanes {addr[1],0} and {addr[1],1} from wdata[15:0].
REQ-027 SW SHALL write all four lanes.
REQ-028 LB/LH SHALL sign-extend the selected byte/half, LBU/LHU SHALL zero-extend it, and LW SHALL return the full word.
REQ-029 Store responses SHALL return rsp_rdata=0 and rsp_err=0.
REQ-030 Memory array SHALL be little-endian, not reset, and backdoor-visible to benches as array mem[0:DEPTH-1].
REQ-031 req_valid deassertion while not ready SHALL have no effect; inputs are ignored outside the IDLE-accept cycle.

Reset
REQ-032 reset=0 SHALL immediately force state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and wait counter=0, regardless of clk.
REQ-033 Reset asserted in WAIT or RESP SHALL abort the transaction; a store not yet committed (still in WAIT) SHALL NOT write memory.
REQ-034 Memory contents SHALL be unchanged by reset.
REQ-035 After reset release, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-036 WAIT_STATES=1: SW addr 0x8, wdata 0xDEADBEEF, then LW 0x8 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each accept.
REQ-037 mem[2]=0x00000000: SB 0x9 data 0x80, then LB 0x9 -> 0xFFFFFF80, LBU 0x9 -> 0x00000080, and LW 0x8 -> 0x00008000.
REQ-038 mem[3]=0x8001_7FFF: LH 0xC -> 0x00007FFF, LH 0xE -> 0xFFFF8001, LHU 0xE -> 0x00008001.
REQ-039 Errors: LW 0x6, LH 0x5, SW 0x100 (DEPTH=64), funct3 011 -> each rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0; then rsp_ready=1 -> IDLE next edge.
REQ-041 WAIT_STATES=3: SW 0x10 accepted, reset pulsed low 1 cycle later -> outputs cleared asynchronously, mem[4] unchanged, req_ready=1.
